// File: rtl/exe_div_sequencer.sv
// Multi-cycle integer divider for the EXE stage: restoring division, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU with divide-by-zero and signed-overflow short cuts.
module exe_div_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_idx_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_idx_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        CALC  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [4:0]  rd_reg, rd_next;
    logic [31:0] quo_reg, quo_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] div_reg, div_next;
    logic        q_neg_reg, q_neg_next;
    logic        r_neg_reg, r_neg_next;
    logic [4:0]  count_reg, count_next;
    logic [31:0] result_reg, result_next;
    logic [4:0]  rd_out_reg, rd_out_next;

    // op_i[0] selects unsigned, op_i[1] selects remainder
    logic        is_signed;
    logic        is_rem;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        overflow;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_signed = ~op_reg[0];
    assign is_rem    = op_reg[1];
    assign abs_a     = (is_signed && a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
    assign abs_b     = (is_signed && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
    assign div_zero  = (b_reg == 32'd0);
    assign overflow  = is_signed && (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);

    // Partial remainder picks up the next dividend bit; a borrow means restore
    assign shifted = {rem_reg, quo_reg[31]};
    assign trial   = shifted - {1'b0, div_reg};

    assign quo_fix = (is_signed && q_neg_reg) ? (~quo_reg + 32'd1) : quo_reg;
    assign rem_fix = (is_signed && r_neg_reg) ? (~rem_reg + 32'd1) : rem_reg;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        rd_next     = rd_reg;
        quo_next    = quo_reg;
        rem_next    = rem_reg;
        div_next    = div_reg;
        q_neg_next  = q_neg_reg;
        r_neg_next  = r_neg_reg;
        count_next  = count_reg;
        result_next = result_reg;
        rd_out_next = rd_out_reg;

        case (state_reg)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_next    = op_i;
                    a_next     = rs1_i;
                    b_next     = rs2_i;
                    rd_next    = rd_idx_i;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                q_neg_next = is_signed && (a_reg[31] ^ b_reg[31]);
                r_neg_next = is_signed && a_reg[31];
                if (div_zero) begin
                    result_next = is_rem ? a_reg : 32'hFFFF_FFFF;
                    rd_out_next = rd_reg;
                    state_next  = DONE;
                end else if (overflow) begin
                    result_next = is_rem ? 32'd0 : 32'h8000_0000;
                    rd_out_next = rd_reg;
                    state_next  = DONE;
                end else begin
                    quo_next   = abs_a;
                    div_next   = abs_b;
                    rem_next   = 32'd0;
                    count_next = 5'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                rem_next   = trial[32] ? shifted[31:0] : trial[31:0];
                quo_next   = {quo_reg[30:0], ~trial[32]};
                count_next = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                result_next = is_rem ? rem_fix : quo_fix;
                rd_out_next = rd_reg;
                state_next  = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A flush abandons the operation without touching the presented result
        if (flush_i) begin
            state_next  = IDLE;
            result_next = result_reg;
            rd_out_next = rd_out_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            op_reg     <= 2'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            rd_reg     <= 5'd0;
            quo_reg    <= 32'd0;
            rem_reg    <= 32'd0;
            div_reg    <= 32'd0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            count_reg  <= 5'd0;
            result_reg <= 32'd0;
            rd_out_reg <= 5'd0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            rd_reg     <= rd_next;
            quo_reg    <= quo_next;
            rem_reg    <= rem_next;
            div_reg    <= div_next;
            q_neg_reg  <= q_neg_next;
            r_neg_reg  <= r_neg_next;
            count_reg  <= count_next;
            result_reg <= result_next;
            rd_out_reg <= rd_out_next;
        end
    end

    // Stall starts in the request cycle itself so ID holds the operands; it drops in DONE
    assign stall_o  = (resetn && (state_reg == IDLE) && start_i && !flush_i)
                    || (state_reg == CHECK) || (state_reg == CALC) || (state_reg == FIX);
    assign busy_o   = (state_reg != IDLE);
    assign done_o   = (state_reg == DONE) && !flush_i;
    assign result_o = result_reg;
    assign rd_idx_o = rd_out_reg;

endmodule

// File: tb/tb_exe_div_sequencer.sv
// Self-checking bench for exe_div_sequencer: directed table, corner sequences, and
// randomized operations against an arithmetic reference model.
module tb_exe_div_sequencer;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_idx_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_idx_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    exe_div_sequencer dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_idx_i (rd_idx_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_idx_o (rd_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_o) done_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division) plus the divide-by-zero rule
    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issue one request from IDLE (at posedge+1) and follow it to completion
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input string nm);
        int lat;
        bit stall_bad;
        lat = 0;
        stall_bad = 0;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_idx_i = rd; flush_i = 1'b0;
        #1;
        if (!stall_o) stall_bad = 1;
        @(posedge clk); #1;
        // Scramble inputs to prove the operands were latched at acceptance
        start_i = 1'b0; op_i = 2'($urandom); rs1_i = $urandom; rs2_i = $urandom;
        rd_idx_i = 5'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                lat = c;
                if (stall_o) stall_bad = 1;
                break;
            end
            if (!stall_o || !busy_o) stall_bad = 1;
            @(posedge clk); #1;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_res"}, result_o, exp_res);
        chk({nm, "_rd"}, 32'(rd_idx_o), 32'(rd));
        chk({nm, "_stall"}, 32'(stall_bad), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, {done_o, busy_o, result_o[29:0]}, {2'b00, exp_res[29:0]});
        last_res = exp_res;
        last_rd = rd;
        $display("op=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", op, a, b, rd, result_o, lat);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        int          d0;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         35};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFF,  35};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFD,  35};
        vecs[3]  = '{2'b01, 32'd1234,       32'd0,          5'd3,  32'hFFFF_FFFF,  2};
        vecs[4]  = '{2'b11, 32'd1234,       32'd0,          5'd4,  32'd1234,       2};
        vecs[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,  2};
        vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0,          2};
        vecs[7]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          35};
        vecs[8]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  35};
        vecs[9]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          35};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF,  32'd10,         5'd31, 32'd5,          35};

        resetn = 1'b0; start_i = 1'b1; op_i = 2'd0; rs1_i = 32'd0; rs2_i = 32'd0;
        rd_idx_i = 5'd0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {stall_o, busy_o, done_o, result_o[23:0], rd_idx_o}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat,
                  $sformatf("vec%0d", i));
        end

        // Flush in the 10th CALC cycle (cycle 11 after acceptance)
        d0 = done_cnt;
        start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd1000; rs2_i = 32'd3; rd_idx_i = 5'd12;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_idle", 32'(busy_o), 32'd0);
        chk("flush_nodone", 32'(done_cnt - d0), 32'd0);
        chk("flush_res", result_o, last_res);
        chk("flush_rd", 32'(rd_idx_o), 32'(last_rd));
        $display("flush at CALC10 -> busy=%0d result=%h", busy_o, result_o);
        do_op(2'b01, 32'd1000, 32'd3, 5'd12, 32'd333, 35, "after_flush");

        // Reset during CALC
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd999; rs2_i = 32'd9; rd_idx_i = 5'd20;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("calc_reset", {stall_o, busy_o, done_o, result_o[23:0], rd_idx_o}, 32'd0);
        $display("reset in CALC -> busy=%0d result=%h rd=%0d", busy_o, result_o, rd_idx_o);
        start_i = 1'b0;
        resetn = 1'b1;
        last_res = 32'd0;
        last_rd = 5'd0;

        // start_i held through the whole operation: one done, DONE->IDLE does not accept
        d0 = done_cnt;
        start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd50; rs2_i = 32'd5; rd_idx_i = 5'd17;
        @(posedge clk); #1;
        repeat (34) @(posedge clk);
        #1;
        chk("held_done", {done_o, stall_o, result_o[29:0]}, {2'b10, 30'd10});
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("held_once", 32'(done_cnt - d0), 32'd1);
        chk("held_idle", 32'(busy_o), 32'd0);
        $display("held start -> dones=%0d result=%h", done_cnt - d0, result_o);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom);
            do_op(rop, ra, rb, rrd, model_res(rop, ra, rb), model_lat(rop, ra, rb),
                  $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_div_sequencer.md
EXE_DIV_SEQUENCER -- requirements
Module: exe_div_sequencer

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 start_i  input  1  divide request from ID stage; sampled only in IDLE.
REQ-004 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 rs1_i  input  32  dividend.
REQ-006 rs2_i  input  32  divisor.
REQ-007 rd_idx_i  input  5  destination register index.
REQ-008 flush_i  input  1  abort current operation (branch/exception flush).
REQ-009 stall_o  output  1  holds IF/ID/EXE pipeline registers while high.
REQ-010 busy_o  output  1  high in every state other than IDLE.
REQ-011 done_o  output  1  one-cycle pulse; result_o and rd_idx_o are valid.
REQ-012 result_o  output  32  quotient or remainder, selected by op_i.
REQ-013 rd_idx_o  output  5  destination index latched at acceptance.

Function
REQ-014 The FSM SHALL have states IDLE, CHECK, CALC, FIX and DONE.
REQ-015 Acceptance: a rising edge with state IDLE, start_i=1 and flush_i=0 SHALL latch op_i, rs1_i, rs2_i and rd_idx_i and move the FSM to CHECK.
REQ-016 CHECK SHALL form the absolute values of the operands (signed ops only) and record the quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)).
REQ-017 CHECK with divisor==0 SHALL go to DONE with quotient=0xFFFFFFFF and remainder=dividend.
REQ-018 CHECK with DIV/REM, dividend=0x80000000 and divisor=0xFFFFFFFF SHALL go to DONE with quotient=0x80000000 and remainder=0.
REQ-019 All other CHECK cases SHALL clear a 5-bit counter and go to CALC.
REQ-020 CALC SHALL perform one restoring-division step per cycle (shift, 33-bit trial subtract, conditional restore, quotient bit), MSB first, for exactly 32 cycles, then go to FIX.
REQ-021 FIX SHALL negate the quotient and/or remainder according to the recorded signs (signed ops only), then go to DONE.
REQ-022 DONE SHALL assert done_o for exactly one cycle, drive result_o (quotient for DIV/DIVU, remainder for REM/REMU) and rd_idx_o, then return to IDLE.
REQ-023 Latency: done_o SHALL be high in the 35th cycle after the accepting edge for normal cases, and in the 2nd cycle for the REQ-017/018 cases.
REQ-024 stall_o SHALL equal (state==IDLE AND start_i AND NOT flush_i) OR state in {CHECK, CALC, FIX}; it SHALL be low in DONE so the pipeline advances while the result is presented.
REQ-025 start_i SHALL be ignored in every state other than IDLE; the DONE→IDLE edge SHALL NOT accept a new request.
REQ-026 flush_i=1 in any state SHALL force IDLE on the next edge, suppress done_o and leave result_o unchanged; flush_i takes priority over start_i.
REQ-027 result_o and rd_idx_o SHALL hold their last DONE values until the next DONE.
REQ-028 All arithmetic SHALL be modulo 2^32; remainder magnitude SHALL always be less than divisor magnitude.

Reset
REQ-029 resetn=0 at an edge SHALL force IDLE, counter=0, stall_o=0, busy_o=0, done_o=0, result_o=0 and rd_idx_o=0, aborting any operation in progress.
REQ-030 Following reset release, the first request SHALL be accepted at the first edge that meets REQ-015.

Verification
REQ-031 DIVU 100/7 with rd=5 -> done_o in cycle 35, result_o=14, rd_idx_o=5, stall_o high in cycles 0-34.
REQ-032 REM -7 (0xFFFFFFF9) / 2 -> result_o=0xFFFFFFFF; DIV of the same operands -> 0xFFFFFFFD.
REQ-033 DIVU 1234/0 -> done_o in cycle 2, result_o=0xFFFFFFFF; REMU 1234/0 -> result_o=1234.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> result_o=0x80000000 in cycle 2; REM of the same operands -> 0.
REQ-035 flush_i pulsed in the 10th CALC cycle -> IDLE next cycle, no done_o, result_o unchanged; a new request in the following cycle completes normally.
REQ-036 resetn low during CALC -> all outputs 0 at the next edge; start_i held high during busy -> exactly one done_o per accepted request.
